key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 21 ++
 rtl/key_debounce_ch.sv | 110 +++++++++++
 rtl/key_debounce.sv | 39 +++
 tb/tb_key_debounce.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the four-key pushbutton debouncer:
// FSM state encoding, counter width and the terminal-count helper.
package key_debounce_pkg;

  localparam int CNT_W    = 24;
  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } db_state_e;

  // Last counter value of a debounce window; the window ends when the
  // counter reaches this value while the new level is still present.
  function automatic logic [CNT_W-1:0] cnt_last(input int debounce_cycles);
    return CNT_W'(debounce_cycles - 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key: two-flop synchroniser, four-state FSM with a 24-bit
// stability counter, and registered level / press / release outputs.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_raw,
  output logic o_key_out,
  output logic o_key_press,
  output logic o_key_release
);

  localparam logic             RELEASED_LVL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST     = cnt_last(DEBOUNCE_CYCLES);

  logic             r_s1;
  logic             r_s2;
  logic             w_pressed;
  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_out;
  logic             r_key_press;
  logic             r_key_release;

  // The synchroniser resets to the released level so that reset release
  // never looks like an edge on the key.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RELEASED_LVL;
      r_s2 <= RELEASED_LVL;
    end else begin
      r_s1 <= i_key_raw;
      r_s2 <= r_s1;
    end
  end

  assign w_pressed = r_s2 ^ RELEASED_LVL;

  // Outputs are updated on the same edge as the state change so key_out and
  // the pulses line up exactly with entry into PRESSED / RELEASED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RELEASED;
      r_cnt         <= '0;
      r_key_out     <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (w_pressed) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_pressed) begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= ST_PRESSED;
            r_cnt       <= '0;
            r_key_out   <= 1'b1;
            r_key_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_pressed) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          // Bounce back to pressed: key_out never dropped, so no pulse.
          if (w_pressed) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= ST_RELEASED;
            r_cnt         <= '0;
            r_key_out     <= 1'b0;
            r_key_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_RELEASED;
          r_cnt     <= '0;
          r_key_out <= 1'b0;
        end
      endcase
    end
  end

  assign o_key_out     = r_key_out;
  assign o_key_press   = r_key_press;
  assign o_key_release = r_key_release;

endmodule

// File: rtl/key_debounce.sv
// Four independent pushbutton debouncers; key_out feeds the key
// read-register slave, key_press / key_release are one-cycle event pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] Key_raw,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  logic [NUM_KEYS-1:0] w_key_out;
  logic [NUM_KEYS-1:0] w_key_press;
  logic [NUM_KEYS-1:0] w_key_release;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst_n         (reset_n),
      .i_key_raw     (Key_raw[k]),
      .o_key_out     (w_key_out[k]),
      .o_key_press   (w_key_press[k]),
      .o_key_release (w_key_release[k])
    );
  end

  assign key_out     = w_key_out;
  assign key_press   = w_key_press;
  assign key_release = w_key_release;

endmodule

// File: tb/tb_key_debounce.sv
// Directed and randomized checks of key_debounce (DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1) against a run-length reference model of the debounce rule.
module tb_key_debounce;

  localparam int DB = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] Key_raw;
  logic [3:0] key_out;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int n_cmp;
  int n_fail;

  // Reference model: raw history two edges deep, accepted level per key and
  // the length of the current run of samples disagreeing with it.
  logic [3:0] h1, h2;
  logic [3:0] lvl;
  logic [3:0] exp_press, exp_rel;
  int         run [4];

  key_debounce #(
    .DEBOUNCE_CYCLES (DB),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Key_raw     (Key_raw),
    .key_out     (key_out),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A level is accepted once DB+1 consecutive synchronised samples disagree
  // with the currently accepted level.
  task automatic model_step();
    exp_press = '0;
    exp_rel   = '0;
    if (!reset_n) begin
      h1  = 4'hF;
      h2  = 4'hF;
      lvl = '0;
      for (int k = 0; k < 4; k++) run[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (~h2[k] != lvl[k]) begin
          run[k]++;
          if (run[k] == DB + 1) begin
            lvl[k] = ~h2[k];
            run[k] = 0;
            if (lvl[k]) exp_press[k] = 1'b1;
            else        exp_rel[k]   = 1'b1;
          end
        end else begin
          run[k] = 0;
        end
      end
      h2 = h1;
      h1 = Key_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("key_out",     key_out,     lvl);
    check("key_press",   key_press,   exp_press);
    check("key_release", key_release, exp_rel);
    check("press_and_release_together", key_press & key_release, 4'h0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [3:0] raw;
    int         hold [4];

    n_cmp   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    Key_raw = 4'hF;
    h1 = 4'hF; h2 = 4'hF; lvl = '0; exp_press = '0; exp_rel = '0;
    for (int k = 0; k < 4; k++) run[k] = 0;

    // Reset with all keys released
    @(negedge clk);
    ticks(3);
    reset_n = 1'b1;
    ticks(3);

    // Clean press on key 0: out and pulse on edge 7
    Key_raw = 4'hE;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("k0_press_level", {3'b000, key_out[0]},   {3'b000, i >= 7});
      check("k0_press_pulse", {3'b000, key_press[0]}, {3'b000, i == 7});
      check("k0_others_idle", key_out[3:1],           3'b000);
    end
    Key_raw = 4'hF;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("k0_release_level", {3'b000, key_out[0]},     {3'b000, i < 7});
      check("k0_release_pulse", {3'b000, key_release[0]}, {3'b000, i == 7});
    end

    // Three-cycle glitch on key 1 is rejected
    Key_raw = 4'hD;
    ticks(3);
    Key_raw = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("k1_glitch_out",   key_out,   4'h0);
      check("k1_glitch_press", key_press, 4'h0);
    end

    // Key 2 held, bounces released for 2 cycles, then released for good
    Key_raw = 4'hB;
    ticks(10);
    Key_raw = 4'hF;
    ticks(2);
    Key_raw = 4'hB;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("k2_bounce_held", {3'b000, key_out[2]}, 4'h1);
    end
    Key_raw = 4'hF;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("k2_release_level", {3'b000, key_out[2]},     {3'b000, i < 7});
      check("k2_release_pulse", {3'b000, key_release[2]}, {3'b000, i == 7});
      check("k2_bounce_no_press", key_press, 4'h0);
    end

    // All four keys pressed together
    Key_raw = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("all_press_level", key_out,   (i >= 7) ? 4'hF : 4'h0);
      check("all_press_pulse", key_press, (i == 7) ? 4'hF : 4'h0);
    end
    Key_raw = 4'hF;
    ticks(9);

    // Reset pulse in the middle of a press window, key still held
    Key_raw = 4'hE;
    ticks(4);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_mid_out",   key_out,   4'h0);
      check("rst_mid_press", key_press, 4'h0);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("post_rst_level", {3'b000, key_out[0]},   {3'b000, i >= 7});
      check("post_rst_pulse", {3'b000, key_press[0]}, {3'b000, i == 7});
    end
    Key_raw = 4'hF;
    ticks(9);

    // Randomized bouncing on all keys with occasional reset pulses
    raw = Key_raw;
    for (int k = 0; k < 4; k++) hold[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          raw[k]  = ~raw[k];
          hold[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 20))
                                                 : int'($urandom_range(1, 6));
        end
        hold[k]--;
      end
      Key_raw = raw;
      reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset_n = 1'b1;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
